jk_cmd_sequencer: RTL and testbench

//  Upstream driver for jk_flipflop: queues HOLD/RESET/SET/TOGGLE commands, each

---
 rtl/jk_cmd_sequencer.sv | 164 ++++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a JK flip-flop: FIFO-queued {j,k} commands with repeat
// counts are played out as registered drive, with a shadow q model and a sticky mismatch check.
module jk_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_count,
  output logic                     j,
  output logic                     k,
  input  logic                     q_in,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err,
  input  logic                     err_clr,
  output logic [7:0]               err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_DRIVE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_mem  [DEPTH];
  logic [CNT_W-1:0] cnt_mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_w;
  logic             push, pop, empty, full;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_cnt, head_rem;

  logic             j_q, j_d, k_q, k_d, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             exp_q_q, exp_q_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  assign level_w   = wr_ptr_q - rd_ptr_q;
  assign empty     = (level_w == '0);
  assign full      = (level_w == FULL_LVL);
  assign push      = cmd_valid && !full;
  assign head_op   = op_mem[rd_ptr_q[AW-1:0]];
  assign head_cnt  = cnt_mem[rd_ptr_q[AW-1:0]];
  // A count of 0 plays once, same as a count of 1.
  assign head_rem  = (head_cnt == '0) ? '0 : head_cnt - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q[AW-1:0]]  <= cmd_op;
      cnt_mem[wr_ptr_q[AW-1:0]] <= cmd_count;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rem_q     <= '0;
      exp_q_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      j_q       <= j_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rem_q     <= rem_d;
      exp_q_q   <= exp_q_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_DRIVE;
      S_DRIVE: if (rem_q == '0 && empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    j_d    = j_q;
    k_d    = k_q;
    busy_d = busy_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        j_d    = 1'b0;
        k_d    = 1'b0;
        busy_d = 1'b0;
        if (!empty) begin
          pop    = 1'b1;
          {j_d, k_d} = head_op;
          rem_d  = head_rem;
          busy_d = 1'b1;
        end
      end
      S_DRIVE: begin
        if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
        end else begin
          done_d = 1'b1;
          // Chain straight into the next queued command so there is no idle gap.
          if (!empty) begin
            pop    = 1'b1;
            {j_d, k_d} = head_op;
            rem_d  = head_rem;
          end else begin
            j_d    = 1'b0;
            k_d    = 1'b0;
            busy_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case ({j_q, k_q})
      2'b00:   exp_q_d = exp_q_q;
      2'b01:   exp_q_d = 1'b0;
      2'b10:   exp_q_d = 1'b1;
      default: exp_q_d = ~exp_q_q;
    endcase
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else if (q_in != exp_q_q) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign cmd_ready = !full;
  assign level     = level_w;
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural JK flip-flop on the
// feedback path; q_in can be overridden to provoke mismatches.
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_count = 4'd0;
  logic       j, k, q_in, busy, done, err;
  logic       err_clr = 1'b0;
  logic [2:0] level;
  logic [7:0] err_cnt;
  logic       q_ff;
  logic       force_en = 1'b0;
  logic       force_val = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) q_ff <= 1'b0;
    else begin
      case ({j, k})
        2'b00: q_ff <= q_ff;
        2'b01: q_ff <= 1'b0;
        2'b10: q_ff <= 1'b1;
        default: q_ff <= ~q_ff;
      endcase
    end
  end

  assign q_in = force_en ? force_val : q_ff;

  jk_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .j(j), .k(k), .q_in(q_in),
    .busy(busy), .done(done), .level(level), .err(err), .err_clr(err_clr),
    .err_cnt(err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; err_clr = 1'b0; force_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; err_clr = 1'b0; force_en = 1'b0;
    tick(); tick();
    total++; if ({j, k} !== 2'b00) begin bad++; $display("FAIL reset_jk got=%b want=00", {j, k}); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (q_ff !== 1'b0) begin bad++; $display("FAIL reset_q got=%b want=0", q_ff); end
    total++; if (err !== 1'b0 || err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err got=%b/%0d want=0/0", err, err_cnt); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    reset = 1'b0;
    tick(); tick();
    total++; if ({j, k, busy, done, err} !== 5'b0 || level !== 3'd0) begin
      bad++; $display("FAIL idle_after_reset got jkbde=%b level=%0d want 00000/0", {j, k, busy, done, err}, level);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ejk [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    logic       eq  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ed  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int dones = 0;
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd1;
    tick();
    cmd_op = 2'b11; cmd_count = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++; if ({j, k} !== ejk[i]) begin bad++; $display("FAIL b2b_jk[%0d] got=%b want=%b", i, {j, k}, ejk[i]); end
      total++; if (q_ff !== eq[i]) begin bad++; $display("FAIL b2b_q[%0d] got=%b want=%b", i, q_ff, eq[i]); end
      total++; if (done !== ed[i]) begin bad++; $display("FAIL b2b_done[%0d] got=%b want=%b", i, done, ed[i]); end
      if (done === 1'b1) dones++;
      tick();
    end
    total++; if (dones !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", dones); end
    total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_err_busy got=%b%b want=00", err, busy); end
  endtask

  task automatic test_fifo_full();
    int waits = 0;
    int max_level = 0;
    do_reset();
    cmd_op = 2'b00; cmd_count = 4'd15; cmd_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL full_ready_pre[%0d] got=%b want=1", n, cmd_ready); end
      tick();
      if (int'(level) > max_level) max_level = int'(level);
    end
    total++; if (max_level !== 4 || level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d max=%0d want=4", level, max_level); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", cmd_ready); end
    while (cmd_ready !== 1'b1 && waits < 40) begin
      total++; if (level !== 3'd4) begin bad++; $display("FAIL full_hold_level got=%0d want=4", level); end
      tick();
      waits++;
    end
    total++; if (waits !== 12) begin bad++; $display("FAIL full_wait_cycles got=%0d want=12", waits); end
    total++; if (level !== 3'd3 || done !== 1'b1) begin bad++; $display("FAIL full_pop got level=%0d done=%b want=3/1", level, done); end
    tick();
    cmd_valid = 1'b0;
    total++; if (level !== 3'd4 || cmd_ready !== 1'b0) begin bad++; $display("FAIL full_late_push got level=%0d ready=%b want=4/0", level, cmd_ready); end
  endtask

  task automatic test_count_zero();
    logic [1:0] ejk [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
    logic       eq  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       ed  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int resets = 0;
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd1;
    tick();
    cmd_op = 2'b01; cmd_count = 4'd0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if ({j, k} !== ejk[i]) begin bad++; $display("FAIL cz_jk[%0d] got=%b want=%b", i, {j, k}, ejk[i]); end
      total++; if (q_ff !== eq[i]) begin bad++; $display("FAIL cz_q[%0d] got=%b want=%b", i, q_ff, eq[i]); end
      total++; if (done !== ed[i]) begin bad++; $display("FAIL cz_done[%0d] got=%b want=%b", i, done, ed[i]); end
      if ({j, k} === 2'b01) resets++;
      tick();
    end
    total++; if (resets !== 1) begin bad++; $display("FAIL cz_reset_cycles got=%0d want=1", resets); end
  endtask

  task automatic test_err();
    do_reset();
    force_en = 1'b1; force_val = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd2;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    total++; if (err !== 1'b0 || err_cnt !== 8'd0) begin bad++; $display("FAIL err_before got=%b/%0d want=0/0", err, err_cnt); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (err !== 1'b1 || err_cnt !== 8'(i)) begin bad++; $display("FAIL err_count[%0d] got=%b/%0d want=1/%0d", i, err, err_cnt, i); end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if (err !== 1'b0 || err_cnt !== 8'd0) begin bad++; $display("FAIL err_clr_wins got=%b/%0d want=0/0", err, err_cnt); end
    force_en = 1'b0;
    tick();
    total++; if (err !== 1'b0 || err_cnt !== 8'd0) begin bad++; $display("FAIL err_after_release got=%b/%0d want=0/0", err, err_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_count = 4'd8;
    tick();
    cmd_op = 2'b10; cmd_count = 4'd1;
    tick();
    cmd_op = 2'b00; cmd_count = 4'd2;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b1 || level !== 3'd2 || {j, k} !== 2'b11) begin
      bad++; $display("FAIL mid_pre got busy=%b level=%0d jk=%b want 1/2/11", busy, level, {j, k});
    end
    reset = 1'b1;
    #1;
    total++; if ({j, k} !== 2'b00 || level !== 3'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_async got jk=%b level=%0d busy=%b ready=%b want 00/0/0/1", {j, k}, level, busy, cmd_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_no_done[%0d] got=%b want=0", i, done); end
    end
    reset = 1'b0;
    tick();
    total++; if ({j, k, busy, done} !== 4'b0 || level !== 3'd0) begin
      bad++; $display("FAIL mid_released got jkbd=%b level=%0d want 0000/0", {j, k, busy, done}, level);
    end
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd1;
    tick();
    cmd_valid = 1'b0;
    tick();
    total++; if ({j, k} !== 2'b10 || busy !== 1'b1) begin bad++; $display("FAIL mid_fresh_drive got jk=%b busy=%b want 10/1", {j, k}, busy); end
    tick();
    total++; if (q_ff !== 1'b1 || done !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL mid_fresh_result got q=%b done=%b err=%b want 1/1/0", q_ff, done, err);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_back_to_back();
    test_fifo_full();
    test_count_zero();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
